// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder sequencer. It adds two WIDTH-bit operands one bit per
//   clock, LSB first. The sum bit comes from a pair of half-adders:
//     HA1 = a^b / a&b
//     HA2 = s1^carry / s1&carry
//   and the carry is c1|c2. A start/busy/done handshake controls it, and the
//   result stays on sum/cout until the next accepted start.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous reset, active HIGH (legacy pin name)
//   start  in   1      operation request, sampled only in IDLE
//   a, b   in   WIDTH  operands, captured when start is accepted
//   busy   out  1      high while bits are being resolved (RUN)
//   done   out  1      one-cycle pulse, sum/cout valid
//   sum    out  WIDTH  (a+b) mod 2^WIDTH, held after done
//   cout   out  1      carry out of bit WIDTH-1, held after done
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one operand bit resolved per clock, WIDTH clocks
// DONE  | single-cycle done pulse, then back to IDLE
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_sh_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s1, c1, c2, sum_bit, carry_nxt, last_bit;

  // Shared half-adder pair.
  assign s1        = a_sh[0] ^ b_sh[0];
  assign c1        = a_sh[0] & b_sh[0];
  assign sum_bit   = s1 ^ carry;
  assign c2        = s1 & carry;
  assign carry_nxt = c1 | c2;

  // The bit resolved in the cycle where cnt == WIDTH-1 is the MSB.
  assign last_bit  = (cnt == LAST_CNT);

  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_sh_nxt = sum_bit;
    end else begin : g_wn
      assign sum_sh_nxt = {sum_bit, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // The shift register is kept apart from the output register. This way
  // sum/cout keep the previous result for the whole RUN phase and change
  // only on the RUN->DONE edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_sh_nxt;
          carry  <= carry_nxt;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= sum_sh_nxt;
            cout <= carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
